// File: rtl/rms_sqrt_arbiter.sv
// rms_sqrt_arbiter
//   Shares one divider->sqrt chain between CHANNELS RMS accumulators.
//   A round-robin arbiter picks one requesting channel per cycle and
//   forwards its numerator/denominator to the divider. Every issued job
//   leaves a {zero_flag, ch_id} tag in an in-order FIFO; each sqrt result
//   pops the head tag and is steered to the owning channel.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   req                      per-channel level request, held until gnt
//   req_num / req_den        per-channel operands, channel i at [i*W +: W]
//   gnt                      one-cycle one-hot grant
//   div_valid/num/den        job strobe and operands to the divider
//   sqrt_valid / sqrt_root   result strobe and root from the sqrt unit
//   res_valid / res_data     one-cycle one-hot result strobe and root
//   busy                     at least one job in flight
//   err                      sticky: sqrt result arrived with no job pending
//
// Handshakes: req is a level that stays high (operands stable) until the
//   channel sees its one-cycle gnt; the requester drops it no later than
//   the cycle after. div_valid, sqrt_valid and res_valid are single-cycle
//   strobes with no back-pressure; the only flow control is the cap of
//   MAXOUT jobs in flight, enforced by withholding grants.

module rms_sqrt_arbiter #(
    parameter int CHANNELS = 4,
    parameter int NUMBITS  = 72,
    parameter int DENBITS  = 8,
    parameter int ROOTBITS = 32,
    parameter int MAXOUT   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*NUMBITS-1:0]  req_num,
    input  logic [CHANNELS*DENBITS-1:0]  req_den,
    output logic [CHANNELS-1:0]          gnt,
    output logic                         div_valid,
    output logic [NUMBITS-1:0]           div_num,
    output logic [DENBITS-1:0]           div_den,
    input  logic                         sqrt_valid,
    input  logic [ROOTBITS-1:0]          sqrt_root,
    output logic [CHANNELS-1:0]          res_valid,
    output logic [ROOTBITS-1:0]          res_data,
    output logic                         busy,
    output logic                         err
);

    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW   = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;
    localparam int CNTW = $clog2(MAXOUT + 1);

    logic [CW-1:0]   rr_ptr;
    logic [CW:0]     tag_mem [MAXOUT];   // {zero_flag, ch_id}
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;

    logic [CHANNELS-1:0] eligible;
    logic [CW-1:0]       sel;
    logic                found;
    logic                issue;
    logic                pop;
    logic                sel_zero;
    logic [CW:0]         head_tag;
    int                  idx;

    // gnt is the registered grant, so it doubles as the previous-cycle
    // grant mask: a channel that is still holding req in the cycle it is
    // being granted cannot be picked a second time.
    always_comb begin
        eligible = req & ~gnt;
        found    = 1'b0;
        sel      = '0;
        idx      = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && eligible[CW'(idx)]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    // Gate on the pre-pop count: a slot freed this cycle is reused next cycle.
    assign issue    = found && (count < CNTW'(MAXOUT));
    assign pop      = sqrt_valid && (count != '0);
    assign sel_zero = (req_den[int'(sel)*DENBITS +: DENBITS] == '0);
    assign head_tag = tag_mem[rd_ptr];
    assign busy     = (count != '0);

    // Tag storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr] <= {sel_zero, sel};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            div_valid <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            res_valid <= '0;
            res_data  <= '0;
            err       <= 1'b0;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            gnt       <= '0;
            div_valid <= issue;
            res_valid <= '0;

            if (issue) begin
                gnt[sel] <= 1'b1;
                div_num  <= req_num[int'(sel)*NUMBITS +: NUMBITS];
                div_den  <= req_den[int'(sel)*DENBITS +: DENBITS];
                wr_ptr   <= (wr_ptr == AW'(MAXOUT - 1)) ? '0 : wr_ptr + AW'(1);
                rr_ptr   <= (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
            end

            if (pop) begin
                res_valid[head_tag[CW-1:0]] <= 1'b1;
                // A zero sample count has no meaningful root; report 0.
                res_data <= head_tag[CW] ? '0 : sqrt_root;
                rd_ptr   <= (rd_ptr == AW'(MAXOUT - 1)) ? '0 : rd_ptr + AW'(1);
            end

            if (sqrt_valid && (count == '0)) err <= 1'b1;

            if (issue && !pop)      count <= count + CNTW'(1);
            else if (!issue && pop) count <= count - CNTW'(1);
        end
    end

endmodule

// File: tb/tb_rms_sqrt_arbiter.sv
// tb_rms_sqrt_arbiter
//   Directed scenarios plus a randomized run, all checked against a
//   queue-based reference of the arbiter (round-robin pick, in-flight
//   cap, in-order tag return) kept in this file.

module tb_rms_sqrt_arbiter;

    localparam int CH = 4;
    localparam int NB = 72;
    localparam int DB = 8;
    localparam int RB = 32;
    localparam int MO = 8;

    logic               clk;
    logic               rst;
    logic [CH-1:0]      req;
    logic [CH*NB-1:0]   req_num;
    logic [CH*DB-1:0]   req_den;
    logic [CH-1:0]      gnt;
    logic               div_valid;
    logic [NB-1:0]      div_num;
    logic [DB-1:0]      div_den;
    logic               sqrt_valid;
    logic [RB-1:0]      sqrt_root;
    logic [CH-1:0]      res_valid;
    logic [RB-1:0]      res_data;
    logic               busy;
    logic               err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int             m_rr;
    int             m_gnt_ch;
    int             m_tags[$];     // ch + 16 * zero_flag, oldest first
    logic [RB-1:0]  exp_q[$];      // expected res_data in return order
    logic [CH-1:0]  exp_gnt;
    logic           exp_dv;
    logic [NB-1:0]  exp_num;
    logic [DB-1:0]  exp_den;
    logic [CH-1:0]  exp_rv;
    logic [RB-1:0]  exp_rd;
    logic           exp_busy;
    logic           exp_err;

    // requester state
    int cool[CH];
    bit hold[CH];

    rms_sqrt_arbiter #(
        .CHANNELS(CH), .NUMBITS(NB), .DENBITS(DB), .ROOTBITS(RB), .MAXOUT(MO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_num(req_num), .req_den(req_den),
        .gnt(gnt), .div_valid(div_valid), .div_num(div_num), .div_den(div_den),
        .sqrt_valid(sqrt_valid), .sqrt_root(sqrt_root),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_rr     = 0;
        m_gnt_ch = -1;
        m_tags.delete();
        exp_q.delete();
        exp_gnt  = '0;
        exp_dv   = 1'b0;
        exp_num  = '0;
        exp_den  = '0;
        exp_rv   = '0;
        exp_rd   = '0;
        exp_busy = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < CH; i++) begin
            cool[i] = 0;
            hold[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req        = '0;
        req_num    = '0;
        req_den    = '0;
        sqrt_valid = 1'b0;
        sqrt_root  = '0;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Advance one clock; the reference consumes the inputs as they stand
    // just before the edge and predicts the outputs visible after it.
    task automatic tick();
        int            pre;
        int            ch;
        int            c;
        int            t;
        bit            found;
        logic [CH-1:0] elig;
        pre   = m_tags.size();
        elig  = req;
        if (m_gnt_ch >= 0) elig[m_gnt_ch] = 1'b0;
        found = 1'b0;
        ch    = 0;
        for (int k = 0; k < CH; k++) begin
            c = (m_rr + k) % CH;
            if (!found && elig[c]) begin
                found = 1'b1;
                ch    = c;
            end
        end
        exp_gnt = '0;
        exp_dv  = 1'b0;
        exp_rv  = '0;
        if (sqrt_valid) begin
            if (pre > 0) begin
                t = m_tags.pop_front();
                exp_rv[t % 16] = 1'b1;
                exp_rd = (t >= 16) ? '0 : sqrt_root;
                exp_q.push_back(exp_rd);
            end else begin
                exp_err = 1'b1;
            end
        end
        if (found && pre < MO) begin
            exp_gnt[ch] = 1'b1;
            exp_dv      = 1'b1;
            exp_num     = req_num[ch*NB +: NB];
            exp_den     = req_den[ch*DB +: DB];
            m_tags.push_back(ch + ((exp_den == 0) ? 16 : 0));
            m_rr     = (ch + 1) % CH;
            m_gnt_ch = ch;
        end else begin
            m_gnt_ch = -1;
        end
        exp_busy = (m_tags.size() != 0);
        @(posedge clk); #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_ops(input int ch, input logic [NB-1:0] n, input logic [DB-1:0] d);
        req_num[ch*NB +: NB] = n;
        req_den[ch*DB +: DB] = d;
    endtask

    task automatic rand_ops(input int ch);
        logic [NB-1:0] n;
        logic [DB-1:0] d;
        n[NB-1:64] = 8'($urandom);
        n[63:32]   = $urandom;
        n[31:0]    = $urandom;
        d          = ($urandom_range(7) == 0) ? '0 : 8'($urandom_range(255));
        set_ops(ch, n, d);
    endtask

    // Requesters: drop on grant (optionally one cycle late), wait one idle
    // cycle, then possibly re-request with fresh operands.
    task automatic drive_reqs(input int raise_pct, input int hold_pct);
        for (int i = 0; i < CH; i++) begin
            if (req[i] && hold[i]) begin
                req[i]  = 1'b0;
                hold[i] = 1'b0;
                cool[i] = 1;
            end else if (req[i] && gnt[i]) begin
                if ($urandom_range(99) < hold_pct) begin
                    hold[i] = 1'b1;
                end else begin
                    req[i]  = 1'b0;
                    cool[i] = 1;
                end
            end else if (!req[i]) begin
                if (cool[i] > 0) cool[i]--;
                else if ($urandom_range(99) < raise_pct) begin
                    rand_ops(i);
                    req[i] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, div_valid, div_num, div_den, res_valid, res_data, busy, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b dv=%b num=%h den=%h rv=%b rd=%h busy=%b err=%b want all 0",
                     gnt, div_valid, div_num, div_den, res_valid, res_data, busy, err);
        end
    endtask

    task automatic test_single_job();
        do_reset();
        set_ops(2, 72'd400, 8'd4);
        req[2] = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0100 || div_valid !== 1'b1 || div_num !== 72'd400 || div_den !== 8'd4) begin
            bad++;
            $display("FAIL single_issue: got gnt=%b dv=%b num=%0d den=%0d want 0100 1 400 4",
                     gnt, div_valid, div_num, div_den);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_busy: got %b want 1", busy);
        end
        req[2]     = 1'b0;
        sqrt_valid = 1'b1;
        sqrt_root  = 32'd10;
        tick();
        sqrt_valid = 1'b0;
        total++;
        if (res_valid !== 4'b0100 || res_data !== 32'd10 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_result: got rv=%b rd=%0d busy=%b want 0100 10 0",
                     res_valid, res_data, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [RB-1:0] roots[CH];
        do_reset();
        for (int i = 0; i < CH; i++) rand_ops(i);
        req = '1;
        for (int k = 0; k < CH; k++) begin
            tick();
            total++;
            if (gnt !== 4'(1 << k) || div_num !== exp_num || div_den !== exp_den) begin
                bad++;
                $display("FAIL rr_grant%0d: got gnt=%b num=%h den=%h want %b %h %h",
                         k, gnt, div_num, div_den, 4'(1 << k), exp_num, exp_den);
            end
            drive_reqs(0, 0);
        end
        for (int k = 0; k < CH; k++) begin
            roots[k]   = $urandom;
            sqrt_valid = 1'b1;
            sqrt_root  = roots[k];
            tick();
            total++;
            if (res_valid !== 4'(1 << k) || res_data !== exp_rd) begin
                bad++;
                $display("FAIL rr_return%0d: got rv=%b rd=%h want %b %h",
                         k, res_valid, res_data, 4'(1 << k), exp_rd);
            end
            drive_reqs(0, 0);
        end
        sqrt_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int grants;
        int guard;
        do_reset();
        grants = 0;
        for (int c = 0; c < 14; c++) begin
            drive_reqs(100, 0);
            tick();
            if (gnt != '0) grants++;
            total++;
            if (gnt !== exp_gnt) begin
                bad++;
                $display("FAIL bp_fill_gnt: cycle %0d got %b want %b", c, gnt, exp_gnt);
            end
        end
        total++;
        if (grants !== MO || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_cap: got grants=%0d busy=%b want %0d 1", grants, busy, MO);
        end
        drive_reqs(100, 0);
        sqrt_valid = 1'b1;
        sqrt_root  = $urandom;
        tick();
        sqrt_valid = 1'b0;
        total++;
        if (gnt !== 4'b0000 || res_valid !== exp_rv || res_data !== exp_rd) begin
            bad++;
            $display("FAIL bp_pop_cycle: got gnt=%b rv=%b rd=%h want 0000 %b %h",
                     gnt, res_valid, res_data, exp_rv, exp_rd);
        end
        void'(exp_q.pop_front());
        drive_reqs(100, 0);
        tick();
        total++;
        if (gnt === 4'b0000 || gnt !== exp_gnt) begin
            bad++;
            $display("FAIL bp_ninth_grant: got %b want %b", gnt, exp_gnt);
        end
        // drain everything still pending
        guard = 0;
        while ((m_tags.size() != 0 || req != '0) && guard < 80) begin
            drive_reqs(0, 0);
            sqrt_valid = (m_tags.size() != 0);
            sqrt_root  = $urandom;
            tick();
            total++;
            if (gnt !== exp_gnt || res_valid !== exp_rv || (exp_rv != '0 && res_data !== exp_rd)) begin
                bad++;
                $display("FAIL bp_drain: got gnt=%b rv=%b rd=%h want %b %b %h",
                         gnt, res_valid, res_data, exp_gnt, exp_rv, exp_rd);
            end
            guard++;
        end
        sqrt_valid = 1'b0;
        total++;
        if (guard >= 80 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain_timeout: got busy=%b cycles=%0d want 0 <80", busy, guard);
        end
    endtask

    task automatic test_zero_den();
        do_reset();
        set_ops(1, 72'd0, 8'd0);
        req[1] = 1'b1;
        tick();
        req[1]     = 1'b0;
        sqrt_valid = 1'b1;
        sqrt_root  = 32'hDEAD;
        tick();
        sqrt_valid = 1'b0;
        total++;
        if (res_valid !== 4'b0010 || res_data !== 32'd0) begin
            bad++;
            $display("FAIL zero_den: got rv=%b rd=%h want 0010 0", res_valid, res_data);
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        sqrt_valid = 1'b1;
        sqrt_root  = $urandom;
        tick();
        sqrt_valid = 1'b0;
        total++;
        if (err !== 1'b1 || res_valid !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_pop: got err=%b rv=%b busy=%b want 1 0000 0", err, res_valid, busy);
        end
        tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        do_reset();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got %b want 0", err);
        end
    endtask

    task automatic test_reset_midflight();
        int guard;
        do_reset();
        for (int i = 0; i < 3; i++) rand_ops(i);
        req   = 4'b0111;
        guard = 0;
        while (m_tags.size() < 3 && guard < 12) begin
            tick();
            drive_reqs(0, 0);
            guard++;
        end
        total++;
        if (guard >= 12 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_fill: got busy=%b cycles=%0d want 1 <12", busy, guard);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({gnt, div_valid, div_num, div_den, res_valid, res_data, busy, err} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got gnt=%b dv=%b rv=%b busy=%b err=%b want all 0",
                     gnt, div_valid, res_valid, busy, err);
        end
        req = '0;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        rand_ops(3);
        req[3] = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b1000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_regrant: got gnt=%b busy=%b want 1000 1", gnt, busy);
        end
        req[3]     = 1'b0;
        sqrt_valid = 1'b1;
        tick();
        total++;
        if (res_valid !== 4'b1000 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_newjob_return: got rv=%b err=%b want 1000 0", res_valid, err);
        end
        tick();
        sqrt_valid = 1'b0;
        total++;
        if (err !== 1'b1 || res_valid !== 4'b0000) begin
            bad++;
            $display("FAIL mid_stale_pop: got err=%b rv=%b want 1 0000", err, res_valid);
        end
    endtask

    task automatic test_random();
        int            guard;
        int            ret_pct;
        logic [RB-1:0] want;
        do_reset();
        guard = 0;
        for (int c = 0; c < 600; c++) begin
            ret_pct = (c < 300) ? 20 : 55;
            drive_reqs((c < 560) ? 40 : 0, 30);
            sqrt_valid = (m_tags.size() != 0) && ($urandom_range(99) < ret_pct);
            sqrt_root  = $urandom;
            tick();
            total++;
            if (gnt !== exp_gnt || div_valid !== exp_dv || busy !== exp_busy || err !== exp_err) begin
                bad++;
                $display("FAIL rand_ctrl: cycle %0d got gnt=%b dv=%b busy=%b err=%b want %b %b %b %b",
                         c, gnt, div_valid, busy, err, exp_gnt, exp_dv, exp_busy, exp_err);
            end
            if (exp_dv) begin
                total++;
                if (div_num !== exp_num || div_den !== exp_den) begin
                    bad++;
                    $display("FAIL rand_operands: cycle %0d got %h/%h want %h/%h",
                             c, div_num, div_den, exp_num, exp_den);
                end
            end
            total++;
            if (res_valid !== exp_rv) begin
                bad++;
                $display("FAIL rand_res_valid: cycle %0d got %b want %b", c, res_valid, exp_rv);
            end
            if (res_valid != '0) begin
                total++;
                want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (res_data !== want) begin
                    bad++;
                    $display("FAIL rand_res_data: cycle %0d got %h want %h", c, res_data, want);
                end
            end
        end
        while (m_tags.size() != 0 && guard < 40) begin
            sqrt_valid = 1'b1;
            sqrt_root  = $urandom;
            tick();
            total++;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            if (res_valid !== exp_rv || res_data !== want) begin
                bad++;
                $display("FAIL rand_drain: got rv=%b rd=%h want %b %h", res_valid, res_data, exp_rv, want);
            end
            guard++;
        end
        sqrt_valid = 1'b0;
        total++;
        if (guard >= 40 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rand_drain_timeout: got busy=%b want 0", busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b0;
        req        = '0;
        req_num    = '0;
        req_den    = '0;
        sqrt_valid = 1'b0;
        sqrt_root  = '0;
        model_clear();
        #2;
        test_reset();
        test_single_job();
        test_round_robin();
        test_backpressure();
        test_zero_den();
        test_empty_pop();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
